// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive on-chip stimulus-and-check engine for a
// combinational gate with N_IN inputs and a single output. Each input vector
// is held for HOLD cycles; the gate output is sampled on the last cycle of the
// hold window and compared with a golden truth table latched at start.
//
// Handshake: start is a single-cycle request, honoured only while idle.
// busy is high for every cycle of the sweep. done is a single-cycle pulse
// in the cycle after the last compare. pass, err_count and first_err_idx
// remain valid from that pulse until the next accepted start.
//
// Optional build macro TRUTH_TABLE_SWEEPER_STOP_ON_ERR_EN: when defined, the
// sweep ends at the first mismatching vector, and stim stays at that vector.
// When it is undefined, the full sweep always runs.
module truth_table_sweeper #(
    parameter int N_IN = 2,
    parameter int HOLD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   golden,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N_IN-1:0] STIM_MAX  = {N_IN{1'b1}};

    logic [1:0]          state_q, state_d;
    logic [7:0]          hold_q, hold_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic [2**N_IN-1:0]  golden_q, golden_d;
    logic [N_IN:0]       err_q, err_d;
    logic [N_IN-1:0]     fei_q, fei_d;
    logic                pass_q, pass_d;

    logic                mismatch;
    logic [N_IN:0]       err_next;

    // Compare result for the vector currently on stim; only acted on at hold end.
    always_comb begin
        mismatch = (dut_out != golden_q[stim_q]);
        err_next = err_q + (N_IN+1)'(mismatch);
    end

    // Next-state logic for the sweep FSM and its datapath.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        stim_d   = stim_q;
        golden_d = golden_q;
        err_d    = err_q;
        fei_d    = fei_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    golden_d = golden;
                    err_d    = '0;
                    fei_d    = '0;
                    pass_d   = 1'b0;
                    hold_d   = '0;
                    stim_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    err_d = err_next;
                    if (mismatch && (err_q == '0)) begin
                        fei_d = stim_q;
                    end
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_ERR_EN
                    if (mismatch) begin
                        // Stop on the failing vector; stim stays frozen there.
                        pass_d  = 1'b0;
                        state_d = FIN;
                    end else if (stim_q == STIM_MAX) begin
                        pass_d  = (err_next == '0);
                        state_d = FIN;
                    end else begin
                        stim_d = stim_q + 1'b1;
                        hold_d = '0;
                    end
`else
                    if (stim_q == STIM_MAX) begin
                        pass_d  = (err_next == '0);
                        state_d = FIN;
                    end else begin
                        stim_d = stim_q + 1'b1;
                        hold_d = '0;
                    end
`endif
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously so reset acts mid-sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            stim_q   <= '0;
            golden_q <= '0;
            err_q    <= '0;
            fei_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            stim_q   <= stim_d;
            golden_q <= golden_d;
            err_q    <= err_d;
            fei_q    <= fei_d;
            pass_q   <= pass_d;
        end
    end

    // Status outputs follow the registered state directly.
    always_comb begin
        stim          = stim_q;
        busy          = (state_q == RUN);
        done          = (state_q == FIN);
        pass          = pass_q;
        err_count     = err_q;
        first_err_idx = fei_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (N_IN=2/HOLD=10 and
// N_IN=3/HOLD=1) driven by a behavioural gate model, checked cycle by cycle
// against expectations derived from the truth table and the sweep timing.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start_a, dut_out_a, busy_a, done_a, pass_a;
    logic [3:0] golden_a;
    logic [1:0] stim_a, fei_a, dbg_a;
    logic [2:0] err_a;

    logic       start_b, dut_out_b, busy_b, done_b, pass_b;
    logic [7:0] golden_b;
    logic [2:0] stim_b, fei_b;
    logic [3:0] err_b;
    logic [1:0] dbg_b;

    truth_table_sweeper #(.N_IN(2), .HOLD(10)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .golden(golden_a),
        .dut_out(dut_out_a), .stim(stim_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_idx(fei_a),
        .dbg_state(dbg_a)
    );

    truth_table_sweeper #(.N_IN(3), .HOLD(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .golden(golden_b),
        .dut_out(dut_out_b), .stim(stim_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_idx(fei_b),
        .dbg_state(dbg_b)
    );

    int         gate_kind;
    logic [7:0] rnd_tbl;
    int         which;
    int         n_cmp = 0;
    int         n_mis = 0;

    // Gate under test: 0 AND, 1 OR, 2 XOR, other = arbitrary table.
    function automatic logic model_gate(input int kind, input int n, input int x,
                                        input logic [7:0] tbl);
        case (kind)
            0: return (x == (1 << n) - 1);
            1: return (x != 0);
            2: return ($countones(x) % 2) == 1;
            default: return tbl[x[2:0]];
        endcase
    endfunction

    always_comb dut_out_a = model_gate(gate_kind, 2, int'(stim_a), rnd_tbl);
    always_comb dut_out_b = model_gate(gate_kind, 3, int'(stim_b), rnd_tbl);

    logic [2:0] stim_m, fei_m;
    logic [3:0] err_m;
    logic       busy_m, done_m, pass_m;

    // Select the instance currently under observation.
    always_comb begin
        if (which == 0) begin
            stim_m = {1'b0, stim_a}; fei_m = {1'b0, fei_a}; err_m = {1'b0, err_a};
            busy_m = busy_a; done_m = done_a; pass_m = pass_a;
        end else begin
            stim_m = stim_b; fei_m = fei_b; err_m = err_b;
            busy_m = busy_b; done_m = done_b; pass_m = pass_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        if (w == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_golden(input int w, input logic [7:0] g);
        if (w == 0) golden_a = g[3:0]; else golden_b = g;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stim"}, 32'(stim_m), 0);
        check({tag, "_busy"}, 32'(busy_m), 0);
        check({tag, "_done"}, 32'(done_m), 0);
        check({tag, "_pass"}, 32'(pass_m), 0);
        check({tag, "_err"},  32'(err_m),  0);
        check({tag, "_fei"},  32'(fei_m),  0);
    endtask

    // One sweep on instance w; re_at/g_at = cycle (after start) at which a
    // stray start pulse / golden change is injected (0 = none).
    task automatic run_sweep(input int w, input int kind, input logic [7:0] g,
                             input int re_at_in, input int g_at);
        int n, hold, nvec, run_len, errs, first, fin_stim, re_at, nd, fei_exp;
        int prefix[0:8];
        logic stop_mode;
        logic e;
        n = (w == 0) ? 2 : 3;
        hold = (w == 0) ? 10 : 1;
        nvec = 1 << n;
        first = -1;
        prefix[0] = 0;
        for (int i = 0; i < nvec; i++) begin
            e = (model_gate(kind, n, i, rnd_tbl) != g[i]);
            prefix[i+1] = prefix[i] + int'(e);
            if (e && first < 0) first = i;
        end
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_ERR_EN
        stop_mode = 1'b1;
`else
        stop_mode = 1'b0;
`endif
        if (stop_mode && first >= 0) begin
            run_len = (first + 1) * hold; errs = 1; fin_stim = first;
        end else begin
            run_len = nvec * hold; errs = prefix[nvec]; fin_stim = nvec - 1;
        end
        fei_exp = (first < 0) ? 0 : first;
        re_at = (re_at_in > run_len + 1) ? 0 : re_at_in;

        which = w;
        gate_kind = kind;
        @(negedge clk);
        set_start(w, 1'b1);
        set_golden(w, g);
        @(negedge clk);
        set_start(w, 1'b0);
        for (int c = 1; c <= run_len + 2; c++) begin
            if (c <= run_len) begin
                nd = (c - 1) / hold;
                check("run_busy", 32'(busy_m), 1);
                check("run_done", 32'(done_m), 0);
                check("run_stim", 32'(stim_m), nd);
                check("run_err",  32'(err_m),  prefix[nd]);
                check("run_fei",  32'(fei_m),  (first >= 0 && first < nd) ? first : 0);
                check("run_pass", 32'(pass_m), 0);
            end else if (c == run_len + 1) begin
                check("fin_busy", 32'(busy_m), 0);
                check("fin_done", 32'(done_m), 1);
                check("fin_pass", 32'(pass_m), (errs == 0) ? 1 : 0);
                check("fin_err",  32'(err_m),  errs);
                check("fin_fei",  32'(fei_m),  fei_exp);
                check("fin_stim", 32'(stim_m), fin_stim);
            end else begin
                check("hold_busy", 32'(busy_m), 0);
                check("hold_done", 32'(done_m), 0);
                check("hold_pass", 32'(pass_m), (errs == 0) ? 1 : 0);
                check("hold_err",  32'(err_m),  errs);
                check("hold_fei",  32'(fei_m),  fei_exp);
                check("hold_stim", 32'(stim_m), fin_stim);
            end
            set_start(w, c == re_at);
            if (c == g_at) set_golden(w, 8'($urandom));
            @(negedge clk);
        end
        set_start(w, 1'b0);
    endtask

    initial begin
        logic [7:0] g;
        int w, kind, nv;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        golden_a = '0; golden_b = '0;
        gate_kind = 0; rnd_tbl = '0; which = 0;
        repeat (2) @(negedge clk);
        which = 0; #1;
        check_zero("rst_a");
        which = 1; #1;
        check_zero("rst_b");
        @(negedge clk);
        rst = 1'b0;

        run_sweep(0, 0, 8'h08, 0, 0);    // AND, correct table
        run_sweep(0, 0, 8'h0E, 0, 0);    // AND vs OR table: idx 1,2 fail
        run_sweep(0, 0, 8'h08, 15, 20);  // stray start and golden change ignored
        run_sweep(0, 0, 8'h08, 41, 0);   // start during FIN ignored

        // Asynchronous reset mid-sweep.
        which = 0; gate_kind = 0;
        @(negedge clk);
        start_a = 1'b1; golden_a = 4'b1000;
        @(negedge clk);
        start_a = 1'b0;
        repeat (24) @(negedge clk);
        rst = 1'b1; #1;
        check_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 0, 8'h08, 0, 0);

        run_sweep(1, 2, 8'h96, 0, 0);    // 3-input XOR, HOLD=1
        run_sweep(0, 0, 8'h09, 0, 0);    // single mismatch at idx 0

        for (int it = 0; it < 12; it++) begin
            w = $urandom_range(0, 1);
            kind = $urandom_range(0, 3);
            rnd_tbl = 8'($urandom);
            nv = (w == 0) ? 4 : 8;
            g = '0;
            for (int i = 0; i < nv; i++) g[i] = model_gate(kind, (w == 0) ? 2 : 3, i, rnd_tbl);
            if ($urandom_range(0, 1) == 1) g = g ^ 8'($urandom_range(0, 255));
            run_sweep(w, kind, g, $urandom_range(0, 45), $urandom_range(0, 45));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesizable, parametrised stimulus-and-check engine for combinational gate DUTs.
- Sweeps every combination of an N_IN-bit input vector in binary order, holding each vector for HOLD clock cycles.
- Samples the DUT's 1-bit output at the end of each hold window and compares it against a golden truth table latched at start.
- Sits beside the gate under test, so labs can run exhaustive self-checking on-chip and report pass/fail plus an error count.

Parameters:
- N_IN, 2, number of DUT inputs; legal range 1..8.
- HOLD, 10, clock cycles each vector is held; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; accepted only in IDLE.
- golden  input  2**N_IN  expected truth table; bit i is the expected output for stim == i.
- dut_out  input  1  DUT output, combinational from stim.
- stim  output  N_IN  vector driven to the DUT inputs.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep finishes.
- pass  output  1  1 if the last completed sweep had zero mismatches.
- err_count  output  N_IN+1  number of mismatches in the current or last sweep.
- first_err_idx  output  N_IN  stim value of the first mismatch; 0 if there was none.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sweep):
  - stim=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0.
  - FSM goes to IDLE; internal hold counter and golden latch are cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 sampled at edge k: latch golden, clear err_count, first_err_idx, pass and the hold counter; set stim=0; go to RUN.
  - busy=1 from cycle k+1.
- RUN:
  - hold_cnt counts 0..HOLD-1 while stim stays stable.
  - At hold_cnt==HOLD-1, compare dut_out with latched_golden[stim].
  - On mismatch: err_count increments; if this is the first mismatch, first_err_idx=stim.
  - Then, if stim == 2**N_IN-1, go to FIN (stim stays at max); otherwise stim increments and hold_cnt=0.
- FIN:
  - busy=0, done=1 for exactly one cycle, pass=(err_count==0); go to IDLE.
- Latency:
  - RUN lasts exactly 2**N_IN * HOLD cycles.
  - done is asserted in cycle k+1+2**N_IN*HOLD.
- Hold-over: pass, err_count and first_err_idx stay valid from FIN until the next accepted start. stim keeps its last value in IDLE.
- start while busy or in FIN: ignored, no restart and no side effects.
- golden changing mid-sweep: no effect, because only the latched copy is used.
- err_count width N_IN+1 holds the maximum 2**N_IN without wrap.
- stim increments in plain binary and never wraps within a sweep.
- HOLD=1: each vector is held for one cycle and compared in that same cycle.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_STOP_ON_ERR_EN.
- Defined: on the first mismatch (at hold end), the FSM goes directly to FIN.
  - err_count=1, first_err_idx is captured, stim freezes at the failing vector.
  - done/pass timing follows the normal FIN rule, one cycle after the failing compare.
- Undefined: the full sweep always completes and all mismatches are counted.

Test Plan:
- N_IN=2, HOLD=10, DUT=AND, golden=4'b1000, start at cycle 0:
  - stim runs 0,1,2,3 with each held 10 cycles.
  - done pulses at cycle 41; pass=1, err_count=0, first_err_idx=0.
- Same setup, golden=4'b1110 (OR table):
  - mismatches at idx 1 and 2 give err_count=2, first_err_idx=1, pass=0 at done (cycle 41).
- Same as the first case, with start re-pulsed at cycle 15 and golden changed to 4'b0000 at cycle 20:
  - both are ignored; done still at cycle 41, pass=1.
- Same as the first case, with rst asserted at cycle 25 for 2 cycles:
  - all outputs read 0 immediately.
  - A new start at cycle 30 gives done at cycle 71, pass=1.
- N_IN=3, HOLD=1, DUT=3-input XOR, golden=8'b10010110:
  - busy for 8 cycles, done at cycle 9, pass=1.
- With STOP_ON_ERR_EN defined, N_IN=2, HOLD=10, DUT=AND, golden=4'b1001:
  - mismatch at idx 0 (cycle 10) leads to done at cycle 11.
  - err_count=1, first_err_idx=0, stim=0, pass=0.
  - Without the macro, the same stimulus gives done at cycle 41 with err_count=1.
